// File: rtl/regfile_dump_reader_if.sv
// regfile_dump_reader_if: valid/ready word stream carrying a register index and its contents
//   out_valid  word valid (master -> slave)
//   out_ready  slave accepts word (slave -> master)
//   out_addr   register index of the current word
//   out_data   register contents
//   out_last   current word is the final word of the dump
interface regfile_dump_reader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    modport master (output out_valid, out_addr, out_data, out_last, input out_ready);
    modport slave  (input out_valid, out_addr, out_data, out_last, output out_ready);
endinterface

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks a register-file address range on read port 1 and streams (addr, data) words
//   clock, reset_n         rising-edge clock, asynchronous active-low reset
//   start, abort           begin a dump (ignored while busy), cancel the dump in progress
//   first_addr, last_addr  inclusive range, sampled on an accepted start
//   rf_addr, rf_data       register file a1 / rd1 (rd1 combinational from a1)
//   out                    valid/ready word stream (master side)
//   busy, done             dump in progress, one-cycle completion pulse
module regfile_dump_reader #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_W-1:0]     first_addr,
    input  logic [ADDR_W-1:0]     last_addr,
    output logic [ADDR_W-1:0]     rf_addr,
    input  logic [DATA_W-1:0]     rf_data,
    output logic                  busy,
    output logic                  done,
    regfile_dump_reader_if.master out
);
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
    state_t state, state_n;
    logic [ADDR_W-1:0] ptr, last_q, addr_q;
    logic [DATA_W-1:0] data_q;
    logic valid_q, last_flag_q;
    logic load, adv, accept, empty, fin, skip, at_last, hs;
    assign hs      = valid_q && out.out_ready;
    assign skip    = SKIP_ZERO && ptr == '0;
    assign at_last = ptr == last_q;
    assign out.out_valid = valid_q;
    assign out.out_addr  = addr_q;
    assign out.out_data  = data_q;
    assign out.out_last  = last_flag_q;
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_n;
    always_comb begin
        state_n = state;
        rf_addr = '0;
        load    = 1'b0;
        adv     = 1'b0;
        accept  = 1'b0;
        empty   = 1'b0;
        fin     = 1'b0;
        case (state)
            IDLE: begin
                accept  = start && !abort && first_addr <= last_addr;
                empty   = start && !abort && first_addr > last_addr;
                state_n = accept ? STREAM : IDLE;
            end
            STREAM: begin
                rf_addr = ptr;
                load    = !abort && !skip && (!valid_q || out.out_ready);
                // a skipped address 0 still advances the walk without producing a word
                adv     = load || (!abort && skip);
                state_n = abort ? IDLE : (adv && at_last) ? DRAIN : STREAM;
            end
            DRAIN: begin
                rf_addr = ptr;
                // valid_q is already low here only when every address was skipped
                fin     = !abort && (!valid_q || out.out_ready);
                state_n = (abort || fin) ? IDLE : DRAIN;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            ptr         <= '0;
            last_q      <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_flag_q <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= fin || empty;
            if (accept) begin
                ptr    <= first_addr;
                last_q <= last_addr;
                busy   <= 1'b1;
            end
            if (adv && !at_last) ptr <= ptr + 1'b1;
            if (load) begin
                data_q      <= rf_data;
                addr_q      <= ptr;
                valid_q     <= 1'b1;
                last_flag_q <= at_last;
            end else if (hs) begin
                valid_q     <= 1'b0;
                last_flag_q <= 1'b0;
            end
            if (fin || abort) busy <= 1'b0;
            if (abort) begin
                valid_q     <= 1'b0;
                last_flag_q <= 1'b0;
            end
        end
endmodule
